light_hash_gen: RTL and testbench

- Parametrised next generation of the AES S-box light hash engine.
- Digest width and rounds per byte are configurable; the ad-hoc valid/state interface becomes a ready/valid command port.
- Adds a running byte counter and a held digest_valid.
- Sits between the byte-stream front end and the digest consumer; one byte absorbed per command.

---
 rtl/light_hash_gen_pkg.sv | 31 +++
 rtl/light_hash_gen_aes_sbox.sv | 45 ++++
 rtl/light_hash_gen.sv | 142 ++++++++++++++
 tb/tb_light_hash_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_hash_gen_pkg.sv
// Shared types and helpers for the light hash engine: command opcodes,
// FSM states, the per-byte chaining IV and the 1-bit left rotate used
// by the round function.
package lh_gen_pkg;

    typedef enum logic [1:0] {
        OP_HEAD = 2'b00,
        OP_MSG  = 2'b10,
        OP_TAIL = 2'b01,
        OP_RSVD = 2'b11
    } lh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_LEN_LO = 2'd2,
        ST_LEN_HI = 2'd3
    } lh_state_e;

    // Chaining-state initial value for byte lane i.
    function automatic logic [7:0] lh_iv_byte(input int unsigned i);
        logic [31:0] iw;
        iw = i;
        return 8'hA5 ^ iw[7:0];
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

endpackage

// File: rtl/light_hash_gen_aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (poly 0x11B, computed as x^254 so that 0 maps to 0) followed by the
// AES affine transform.  Ports: in_i (byte in), out_o (substituted byte).
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128
    always_comb begin
        sq  = gf_mul(in_i, in_i);
        inv = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign out_o = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/light_hash_gen.sv
// Light hash engine: absorbs one byte per MSG command through ROUNDS
// S-box rounds over a DIGEST_BYTES-wide chaining state; TAIL publishes
// the digest.  Latency: MSG busy ROUNDS cycles, TAIL 0 cycles (2*ROUNDS
// with LH_LENGTH_STRENGTH_EN defined, which appends the 16-bit message
// length before finalising).  Backpressure: cmd_ready is high only in
// IDLE; the source must hold its command until accepted.
// Ports: clk/rst (async active-high), cmd_valid/cmd_ready/cmd_op/cmd_byte
// command port, digest/digest_valid result, msg_count bytes since HEAD.
module light_hash_gen
    import lh_gen_pkg::*;
#(
    parameter int DIGEST_BYTES = 8,
    parameter int ROUNDS       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [7:0]                cmd_byte,
    output logic [8*DIGEST_BYTES-1:0] digest,
    output logic                      digest_valid,
    output logic [15:0]               msg_count
);

    localparam int DW = 8 * DIGEST_BYTES;

    lh_state_e         state_q;
    logic [DW-1:0]     h_q;
    logic [DW-1:0]     h_d;
    logic [DW-1:0]     iv_vec;
    logic [7:0]        r_q;
    logic [7:0]        m_q;
    logic              cmd_ready_q;
    logic [DW-1:0]     digest_q;
    logic              digest_valid_q;
    logic [15:0]       msg_count_q;
    logic              last_round;

    // One round updates every lane from the old state of its upper neighbour.
    for (genvar gi = 0; gi < DIGEST_BYTES; gi++) begin : g_lane
        localparam int NX = (gi + 1) % DIGEST_BYTES;
        logic [7:0] sb_in;
        logic [7:0] sb_out;
        assign sb_in = h_q[8*NX +: 8] ^ m_q ^ r_q;
        aes_sbox u_sbox (
            .in_i  (sb_in),
            .out_o (sb_out)
        );
        assign h_d[8*gi +: 8]    = sb_out ^ rotl1(h_q[8*gi +: 8]);
        assign iv_vec[8*gi +: 8] = lh_iv_byte(gi);
    end

    assign last_round = (r_q == 8'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            h_q            <= iv_vec;
            r_q            <= '0;
            m_q            <= '0;
            cmd_ready_q    <= 1'b1;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            msg_count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        case (lh_op_e'(cmd_op))
                            OP_HEAD: begin
                                h_q            <= iv_vec;
                                msg_count_q    <= '0;
                                digest_valid_q <= 1'b0;
                            end
                            OP_MSG: begin
                                m_q            <= cmd_byte;
                                r_q            <= '0;
                                msg_count_q    <= msg_count_q + 16'd1;
                                digest_valid_q <= 1'b0;
                                state_q        <= ST_ROUND;
                                cmd_ready_q    <= 1'b0;
                            end
                            OP_TAIL: begin
`ifdef LH_LENGTH_STRENGTH_EN
                                m_q         <= msg_count_q[7:0];
                                r_q         <= '0;
                                state_q     <= ST_LEN_LO;
                                cmd_ready_q <= 1'b0;
`else
                                digest_q       <= h_q;
                                digest_valid_q <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ROUND: begin
                    h_q <= h_d;
                    r_q <= r_q + 8'd1;
                    if (last_round) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
`ifdef LH_LENGTH_STRENGTH_EN
                ST_LEN_LO: begin
                    h_q <= h_d;
                    r_q <= r_q + 8'd1;
                    if (last_round) begin
                        m_q     <= msg_count_q[15:8];
                        r_q     <= '0;
                        state_q <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    h_q <= h_d;
                    r_q <= r_q + 8'd1;
                    if (last_round) begin
                        // Final round result goes straight to the digest.
                        digest_q       <= h_d;
                        digest_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                        cmd_ready_q    <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign msg_count    = msg_count_q;

endmodule

// File: tb/tb_light_hash_gen.sv
module tb_light_hash_gen;

    localparam int ROUNDS = 4;
    localparam logic [1:0] OP_HEAD = 2'b00;
    localparam logic [1:0] OP_MSG  = 2'b10;
    localparam logic [1:0] OP_TAIL = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [63:0] IV8 = 64'hA2A3A0A1A6A7A4A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_byte;
    logic        cmd_ready, cmd_ready4;
    logic [63:0] digest;
    logic [31:0] digest4;
    logic        digest_valid, digest_valid4;
    logic [15:0] msg_count, msg_count4;

    int n_checks = 0;
    int n_fail   = 0;

    light_hash_gen #(.DIGEST_BYTES(8), .ROUNDS(ROUNDS)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .digest(digest),
        .digest_valid(digest_valid), .msg_count(msg_count)
    );

    light_hash_gen #(.DIGEST_BYTES(4), .ROUNDS(ROUNDS)) u_dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .digest(digest4),
        .digest_valid(digest_valid4), .msg_count(msg_count4)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [256];
    logic [7:0]  mh [2][8];          // [0]: 8-byte engine, [1]: 4-byte engine
    logic [15:0] m_count;
    logic [63:0] m_dig8;
    logic [31:0] m_dig4;
    logic        m_dv;

    // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int k = 0; k < 8; k++)
            if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011B << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int k = 0; k < 8; k++)
                s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
            sbox_t[x] = s;
        end
    endtask

    task automatic model_iv();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 8; i++) mh[w][i] = 8'hA5 ^ 8'(i);
    endtask

    task automatic model_reset();
        model_iv();
        m_count = 16'h0; m_dig8 = 64'h0; m_dig4 = 32'h0; m_dv = 1'b0;
    endtask

    task automatic absorb_ref(input logic [7:0] m);
        logic [7:0] nxt [8];
        int n;
        for (int w = 0; w < 2; w++) begin
            n = (w == 0) ? 8 : 4;
            for (int r = 0; r < ROUNDS; r++) begin
                for (int i = 0; i < n; i++)
                    nxt[i] = sbox_t[mh[w][(i+1)%n] ^ m ^ 8'(r)] ^ {mh[w][i][6:0], mh[w][i][7]};
                for (int i = 0; i < n; i++) mh[w][i] = nxt[i];
            end
        end
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] b);
        case (op)
            OP_HEAD: begin model_iv(); m_count = 16'h0; m_dv = 1'b0; end
            OP_MSG:  begin absorb_ref(b); m_count = m_count + 16'd1; m_dv = 1'b0; end
            OP_TAIL: begin
`ifdef LH_LENGTH_STRENGTH_EN
                absorb_ref(m_count[7:0]);
                absorb_ref(m_count[15:8]);
`endif
                for (int i = 0; i < 8; i++) m_dig8[8*i +: 8] = mh[0][i];
                for (int i = 0; i < 4; i++) m_dig4[8*i +: 8] = mh[1][i];
                m_dv = 1'b1;
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_state();
        chk("digest8", digest, m_dig8);
        chk("digest4", 64'(digest4), 64'(m_dig4));
        chk("digest_valid", 64'(digest_valid), 64'(m_dv));
        chk("digest_valid4", 64'(digest_valid4), 64'(m_dv));
        chk("msg_count", 64'(msg_count), 64'(m_count));
        chk("msg_count4", 64'(msg_count4), 64'(m_count));
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        chk("cmd_ready4", 64'(cmd_ready4), 64'd1);
    endtask

    // Issue one command, wait for acceptance, measure the busy window.
    task automatic send(input logic [1:0] op, input logic [7:0] b, input bit hold);
        int wait_c, busy, exp_busy;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_byte = b;
        wait_c = 0;
        while (!cmd_ready && wait_c < 100) begin wait_c++; @(negedge clk); end
        if (wait_c >= 100) chk("accept_timeout", 64'(wait_c), 64'd0);
        @(posedge clk);
        model_apply(op, b);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        busy = 0;
        while (!cmd_ready && busy < 1000) begin busy++; @(negedge clk); end
        cmd_valid = 1'b0;
        exp_busy = 0;
        if (op == OP_MSG) exp_busy = ROUNDS;
`ifdef LH_LENGTH_STRENGTH_EN
        if (op == OP_TAIL) exp_busy = 2 * ROUNDS;
`endif
        chk("busy_cycles", 64'(busy), 64'(exp_busy));
        check_state();
    endtask

    task automatic hash_string(input string s, output logic [63:0] d);
        send(OP_HEAD, 8'h00, 1'b0);
        for (int i = 0; i < s.len(); i++) send(OP_MSG, s[i], 1'b0);
        send(OP_TAIL, 8'h00, 1'b0);
        d = digest;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] d1, d2;
        int len;
        build_sbox();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HEAD; cmd_byte = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_digest", digest, 64'h0);
        chk("rst_msg_count", 64'(msg_count), 64'h0);
        check_state();

        // Empty message
        send(OP_HEAD, 8'h00, 1'b0);
        send(OP_TAIL, 8'h00, 1'b0);
`ifndef LH_LENGTH_STRENGTH_EN
        chk("empty_iv8", digest, IV8);
        chk("empty_iv4", 64'(digest4), 64'h00000000A6A7A4A5);
`else
        chk("len_empty_neq_iv", 64'(digest != IV8), 64'd1);
`endif

        // Single byte
        send(OP_HEAD, 8'h00, 1'b0);
        send(OP_MSG, 8'h41, 1'b0);
        chk("one_byte_count", 64'(msg_count), 64'd1);
        chk("one_byte_dv_low", 64'(digest_valid), 64'd0);
        send(OP_TAIL, 8'h00, 1'b0);
        chk("one_byte_neq_iv", 64'(digest != IV8), 64'd1);

        // Determinism and avalanche
        hash_string("Hardware_and_Embedded_Security", d1);
        hash_string("Hardware_and_Embedded_Security", d2);
        chk("determinism", 64'(d1 == d2), 64'd1);
        chk("count30", 64'(msg_count), 64'd30);
        hash_string("AlessandroAndGiacomo", d1);
        hash_string("AlessandroandGiacomo", d2);
        chk("avalanche", 64'(d1 != d2), 64'd1);

        // Reserved op leaves everything alone; TAIL afterwards re-publishes same H
        send(OP_RSVD, 8'h5A, 1'b0);
        send(OP_TAIL, 8'h00, 1'b0);

        // MSG after TAIL drops digest_valid (extension mode)
        send(OP_MSG, 8'h33, 1'b0);
        chk("dv_drop", 64'(digest_valid), 64'd0);

        // Command held through busy window: accepted only once
        send(OP_MSG, 8'h77, 1'b1);
        send(OP_TAIL, 8'h00, 1'b0);

        // 3-byte message (length bytes 03,00 in the strengthened build)
        send(OP_HEAD, 8'h00, 1'b0);
        send(OP_MSG, 8'h01, 1'b0);
        send(OP_MSG, 8'h02, 1'b0);
        send(OP_MSG, 8'h03, 1'b0);
        send(OP_TAIL, 8'h00, 1'b0);

        // Reset in the middle of a MSG round sequence
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_MSG; cmd_byte = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_digest", digest, 64'h0);
        chk("midrst_dv", 64'(digest_valid), 64'd0);
        chk("midrst_count", 64'(msg_count), 64'd0);
        send(OP_HEAD, 8'h00, 1'b0);
        send(OP_TAIL, 8'h00, 1'b0);
`ifndef LH_LENGTH_STRENGTH_EN
        chk("midrst_iv", digest, IV8);
`endif

        // Randomised traffic, including extension mode and reserved ops
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 12);
            if ($urandom_range(0, 4) != 0) send(OP_HEAD, 8'h00, 1'b0);
            for (int j = 0; j < len; j++) begin
                send(OP_MSG, 8'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 9) == 0) send(OP_RSVD, 8'($urandom), 1'b0);
            end
            send(OP_TAIL, 8'h00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
